// File: rtl/ifd_mem_responder.sv
// ifd_mem_responder
//   Memory-side responder for the IFD instruction-fetch read port. Holds a
//   2^ADDR_WIDTH x DATA_WIDTH instruction memory and answers every accepted
//   fetch exactly RD_LATENCY edges after the request was sampled.
//
// Ports
//   clk           free-running clock
//   reset_n       asynchronous active-low reset (memory contents survive it)
//   ifu_rd_req    fetch request, sampled at posedge
//   ifu_rd_addr   fetch address, sampled only when a request is accepted
//   ifu_rd_data   fetched word, held until the next response
//   ld_en         backdoor write enable
//   ld_addr       backdoor write address
//   ld_data       backdoor write data
//   rsp_valid     one-cycle pulse: ifu_rd_data changed on the preceding edge
//   busy          a fetch is outstanding
//   proto_err     sticky: a request arrived while none could be accepted
//   rd_count      accepted fetches, saturating at all-ones
//   last_rd_addr  address of the most recently accepted fetch
//
// FSM
//   state  | meaning
//   IDLE   | nothing outstanding, any request is accepted
//   WAIT   | fetch outstanding; cnt counts RD_LATENCY down to 1, and at 1 the
//          | response is delivered and a new request may be accepted

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module ifd_mem_responder #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  rsp_valid,
    output logic                  busy,
    output logic                  proto_err,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [ADDR_WIDTH-1:0] last_rd_addr
);

    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
        $fatal(1, "ifd_mem_responder: RD_LATENCY must be in 1..15");
    end

    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0]          LAT     = 4'(RD_LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic                  complete;
    logic                  accept;
    logic                  reject;
    logic [DATA_WIDTH-1:0] pend_data;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // ---------------------------------------------------------------
    // Next-state and control decode
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = (state == S_WAIT);
        // The edge that delivers a response is also the first edge on
        // which a new fetch may be taken, which gives full throughput
        // at RD_LATENCY=1.
        complete  = (state == S_WAIT) && (cnt == 4'd1);
        accept    = ifu_rd_req && ((state == S_IDLE) || complete);
        reject    = ifu_rd_req && (state == S_WAIT) && (cnt != 4'd1);

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = LAT;
                end
            end
            S_WAIT: begin
                if (accept) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = LAT;
                end else if (complete) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt   = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Response datapath and status
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ifu_rd_data  <= '0;
            rsp_valid    <= 1'b0;
            proto_err    <= 1'b0;
            rd_count     <= '0;
            last_rd_addr <= '0;
            pend_data    <= '0;
        end else begin
            rsp_valid <= complete;
            // The outgoing word is taken from pend_data before it is
            // overwritten by a fetch accepted on the same edge.
            if (complete) begin
                ifu_rd_data <= pend_data;
            end
            if (reject) begin
                proto_err <= 1'b1;
            end
            if (accept) begin
                // Sampled from the array before this edge's backdoor write
                // lands, so a same-address load returns the old word.
                pend_data    <= mem[ifu_rd_addr];
                last_rd_addr <= ifu_rd_addr;
                if (rd_count != {CNT_WIDTH{1'b1}}) begin
                    rd_count <= rd_count + CNT_ONE;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Instruction memory: not reset, so an image survives reset_n.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_ifd_mem_responder.sv
// Bench for ifd_mem_responder. Three instances (latency 1, 3, 4) share the
// same stimulus; a transaction-level reference model predicts each one.
module tb_ifd_mem_responder;

    localparam int AW = 12;
    localparam int DW = 12;
    localparam int NI = 3;
    localparam logic [AW-1:0] START_ADDRESS = 12'o200;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    logic [DW-1:0] o_data  [NI];
    logic          o_valid [NI];
    logic          o_busy  [NI];
    logic          o_err   [NI];
    logic [AW-1:0] o_last  [NI];
    logic [7:0]    cnt_l1;
    logic [15:0]   cnt_l3;
    logic [15:0]   cnt_l4;

    always #5 clk = ~clk;

    ifd_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .CNT_WIDTH(8)) u_l1 (
        .clk(clk), .reset_n(reset_n), .ifu_rd_req(req), .ifu_rd_addr(addr),
        .ifu_rd_data(o_data[0]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rsp_valid(o_valid[0]), .busy(o_busy[0]), .proto_err(o_err[0]),
        .rd_count(cnt_l1), .last_rd_addr(o_last[0]));

    ifd_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3), .CNT_WIDTH(16)) u_l3 (
        .clk(clk), .reset_n(reset_n), .ifu_rd_req(req), .ifu_rd_addr(addr),
        .ifu_rd_data(o_data[1]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rsp_valid(o_valid[1]), .busy(o_busy[1]), .proto_err(o_err[1]),
        .rd_count(cnt_l3), .last_rd_addr(o_last[1]));

    ifd_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(4), .CNT_WIDTH(16)) u_l4 (
        .clk(clk), .reset_n(reset_n), .ifu_rd_req(req), .ifu_rd_addr(addr),
        .ifu_rd_data(o_data[2]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rsp_valid(o_valid[2]), .busy(o_busy[2]), .proto_err(o_err[2]),
        .rd_count(cnt_l4), .last_rd_addr(o_last[2]));

    // Reference model: per instance, the cycle a response is due and the
    // first cycle at which a new request may be accepted.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            cyc = 0;
    int            free_at  [NI];
    int            due_at   [NI];
    bit            has_due  [NI];
    logic [DW-1:0] due_data [NI];
    logic [DW-1:0] m_data   [NI];
    bit            m_valid  [NI];
    bit            m_err    [NI];
    int            m_cnt    [NI];
    logic [AW-1:0] m_last   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    function automatic int cmax_of(int k);
        return (k == 0) ? 255 : 65535;
    endfunction

    function automatic logic [31:0] got_cnt(int k);
        return (k == 0) ? 32'(cnt_l1) : (k == 1) ? 32'(cnt_l3) : 32'(cnt_l4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            free_at[k] = 0; due_at[k] = 0; has_due[k] = 0; due_data[k] = '0;
            m_data[k] = '0; m_valid[k] = 0; m_err[k] = 0; m_cnt[k] = 0; m_last[k] = '0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            m_valid[k] = 0;
            if (has_due[k] && due_at[k] == cyc) begin
                m_data[k]  = due_data[k];
                m_valid[k] = 1;
                has_due[k] = 0;
            end
            if (req) begin
                if (cyc >= free_at[k]) begin
                    due_data[k] = ref_mem[addr];
                    due_at[k]   = cyc + lat_of(k);
                    free_at[k]  = cyc + lat_of(k);
                    has_due[k]  = 1;
                    if (m_cnt[k] < cmax_of(k)) m_cnt[k]++;
                    m_last[k]   = addr;
                end else begin
                    m_err[k] = 1;
                end
            end
        end
        if (ld_en) ref_mem[ld_addr] = ld_data;
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("L%0d data", lat_of(k)), 32'(o_data[k]), 32'(m_data[k]));
            check($sformatf("L%0d rsp_valid", lat_of(k)), 32'(o_valid[k]), 32'(m_valid[k]));
            check($sformatf("L%0d busy", lat_of(k)), 32'(o_busy[k]), 32'(has_due[k]));
            check($sformatf("L%0d proto_err", lat_of(k)), 32'(o_err[k]), 32'(m_err[k]));
            check($sformatf("L%0d rd_count", lat_of(k)), got_cnt(k), 32'(m_cnt[k]));
            check($sformatf("L%0d last_addr", lat_of(k)), 32'(o_last[k]), 32'(m_last[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (reset_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit r, input logic [AW-1:0] a, input bit le,
                         input logic [AW-1:0] la, input logic [DW-1:0] ld);
        req = r; addr = a; ld_en = le; ld_addr = la; ld_data = ld;
    endtask

    task automatic idle(input int n);
        drive(0, '0, 0, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(0, '0, 1, a, d);
        step();
        drive(0, '0, 0, '0, '0);
    endtask

    // Called just after a posedge; reset is asserted mid-cycle and the
    // outputs must already be zero before the next edge.
    task automatic pulse_reset();
        drive(0, '0, 0, '0, '0);
        reset_n = 1'b0;
        model_reset();
        #2;
        check_all();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] w10;
        logic [DW-1:0] w11;
        model_reset();
        step();
        step();
        reset_n = 1'b1;
        step();

        for (int a = 0; a < 64; a++) load(AW'(a), DW'($urandom));

        // 1: reset clears outputs asynchronously, memory is retained
        load(START_ADDRESS, 12'o7402);
        drive(1, 12'o5, 0, '0, '0);
        step();
        idle(5);
        pulse_reset();
        drive(1, START_ADDRESS, 0, '0, '0);
        step();
        idle(1);
        check("t1 retained", 32'(o_data[0]), 32'(12'o7402));
        idle(4);

        // 2: single fetch at latency 1
        pulse_reset();
        load(12'o200, 12'o7402);
        drive(1, 12'o200, 0, '0, '0);
        step();
        idle(1);
        check("t2 data", 32'(o_data[0]), 32'(12'o7402));
        check("t2 valid", 32'(o_valid[0]), 32'd1);
        check("t2 count", 32'(cnt_l1), 32'd1);
        check("t2 last", 32'(o_last[0]), 32'(12'o200));
        idle(4);

        // 3: back-to-back at latency 1
        pulse_reset();
        load(12'o200, 12'o1234);
        load(12'o201, 12'o7001);
        load(12'o202, 12'o5200);
        load(12'o203, 12'o7402);
        for (int i = 0; i < 4; i++) begin
            drive(1, 12'o200 + AW'(i), 0, '0, '0);
            step();
        end
        idle(1);
        check("t3 last word", 32'(o_data[0]), 32'(12'o7402));
        check("t3 proto_err", 32'(o_err[0]), 32'd0);
        check("t3 count", 32'(cnt_l1), 32'd4);
        idle(5);

        // 4: latency 3, request during WAIT is a protocol error
        pulse_reset();
        w10 = ref_mem[12'o10];
        w11 = ref_mem[12'o11];
        drive(1, 12'o10, 0, '0, '0); step();
        drive(1, 12'o10, 0, '0, '0); step();
        check("t4 err", 32'(o_err[1]), 32'd1);
        check("t4 count", 32'(cnt_l3), 32'd1);
        idle(1);
        drive(1, 12'o11, 0, '0, '0); step();
        check("t4 rsp1", 32'(o_data[1]), 32'(w10));
        idle(3);
        check("t4 rsp2", 32'(o_data[1]), 32'(w11));
        check("t4 err sticky", 32'(o_err[1]), 32'd1);
        idle(3);

        // 5: backdoor write colliding with a fetch returns the old word
        pulse_reset();
        load(12'o50, 12'o1111);
        drive(1, 12'o50, 1, 12'o50, 12'o2222);
        step();
        idle(5);
        check("t5 old word", 32'(o_data[2]), 32'(12'o1111));
        drive(1, 12'o50, 0, '0, '0);
        step();
        idle(5);
        check("t5 new word", 32'(o_data[2]), 32'(12'o2222));

        // 6: reset mid-fetch discards the pending response
        pulse_reset();
        drive(1, 12'o7, 0, '0, '0);
        step();
        idle(2);
        pulse_reset();
        idle(6);
        check("t6 data", 32'(o_data[2]), 32'd0);
        check("t6 count", 32'(cnt_l4), 32'd0);

        // Random traffic, including counter saturation on the 8-bit instance
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                drive(bit'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                      ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 63)), DW'($urandom));
                step();
            end
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifd_mem_responder.md
Name: ifd_mem_responder

Overview:
- Memory-side responder for the IFD instruction-fetch read port (ifu_rd_req / ifu_rd_addr / ifu_rd_data).
- Holds a 2^ADDR_WIDTH x DATA_WIDTH instruction memory.
- Answers each accepted fetch after a fixed, parameterised latency.
- Bench-side: provides a backdoor load port, plus response-valid, busy, protocol-error and fetch-count outputs.
- Sits between the instruction decoder and the bench/memory image.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH (12): fetch address width; memory depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, `DATA_WIDTH (12): instruction word width.
- RD_LATENCY, 1: edges from request sample to data update. Legal range 1..15; out-of-range values are a $fatal at elaboration.
- CNT_WIDTH, 16: width of the fetch counter.

Ports:
- clk  in  1  free-running clock.
- reset_n  in  1  asynchronous, active-low reset.
- ifu_rd_req  in  1  fetch request from the instruction decoder, sampled at posedge.
- ifu_rd_addr  in  ADDR_WIDTH  fetch address, valid with ifu_rd_req.
- ifu_rd_data  out  DATA_WIDTH  fetched instruction word; held until the next response.
- ld_en  in  1  backdoor write enable.
- ld_addr  in  ADDR_WIDTH  backdoor write address.
- ld_data  in  DATA_WIDTH  backdoor write data.
- rsp_valid  out  1  one-cycle pulse: ifu_rd_data updated on the preceding edge.
- busy  out  1  a fetch is outstanding.
- proto_err  out  1  sticky; a request arrived while one could not be accepted.
- rd_count  out  CNT_WIDTH  accepted fetches, saturating.
- last_rd_addr  out  ADDR_WIDTH  address of the most recently accepted fetch.

Behaviour:
- Reset (async, reset_n=0), all outputs forced immediately:
  - ifu_rd_data=0, rsp_valid=0, busy=0, proto_err=0, rd_count=0, last_rd_addr=0.
  - Latency counter=0, state=IDLE.
  - Memory array is NOT cleared; contents survive reset.
- States: IDLE, WAIT.
  - IDLE: busy=0.
  - WAIT: busy=1. Down-counter cnt runs from RD_LATENCY to 1.
- Accept condition, evaluated at posedge: ifu_rd_req && (state==IDLE || (state==WAIT && cnt==1)).
- On accept:
  - Read mem[ifu_rd_addr] into the pending-data register. This is read-before-write: an ld_en to the same address on the same edge returns the old word.
  - last_rd_addr <= ifu_rd_addr.
  - rd_count increments; it holds at all-ones.
  - cnt <= RD_LATENCY; state <= WAIT.
- WAIT, each edge:
  - If cnt>1: cnt decrements.
  - If cnt==1: ifu_rd_data <= pending data; rsp_valid=1 for the following cycle; state <= IDLE unless a new request is accepted on the same edge.
- Latency: request sampled at edge N gives ifu_rd_data valid after edge N+RD_LATENCY.
  - RD_LATENCY=1 sustains one fetch per cycle.
  - RD_LATENCY=k sustains one fetch per k cycles.
- Protocol error:
  - ifu_rd_req while in WAIT with cnt>1 sets proto_err (sticky until reset).
  - The request is dropped: no count, no address capture.
  - The outstanding fetch completes normally.
- Backdoor load:
  - ld_en writes mem[ld_addr] <= ld_data at posedge.
  - Legal in any state.
  - Never alters an already-captured pending word.
- ifu_rd_data holds between responses. It is never driven to X or 0 except by reset.
- Reset mid-fetch: the pending fetch is discarded; no rsp_valid occurs after reset deasserts.
- Address wrap: none needed; every ADDR_WIDTH value is a valid index.
- ifu_rd_addr is only sampled on accept.

Test Plan:
1. Reset: assert reset_n=0 mid-cycle -> all outputs 0 asynchronously, before the next edge. Preload mem[`START_ADDRESS] via ld, pulse reset, then read `START_ADDRESS -> preloaded word returned (memory retained).
2. RD_LATENCY=1: load mem['o200]='o7402 (HLT), req addr 'o200 at edge N -> ifu_rd_data='o7402 and rsp_valid=1 after edge N+1; rd_count=1, last_rd_addr='o200.
3. RD_LATENCY=1 back-to-back: reqs on 4 consecutive edges to 'o200..'o203 holding 'o1234, 'o7001, 'o5200, 'o7402 -> data in order one per cycle, rsp_valid high 4 cycles, proto_err=0, rd_count=4.
4. RD_LATENCY=3: req 'o10 at edge N, second req at N+1 -> proto_err=1 (sticky), rd_count=1, response for 'o10 at N+3. A req at N+3 is accepted, response at N+6.
5. Load collision: mem['o50]='o1111; at the same edge ld_en writes 'o2222 to 'o50 and req 'o50 -> response 'o1111; a subsequent read -> 'o2222.
6. Reset mid-fetch: RD_LATENCY=4, req at N, reset_n low at N+2 for 1 cycle -> no rsp_valid, busy=0, ifu_rd_data=0, rd_count=0.
